// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit and receive blocks.
//   uart_state_e  - frame state encoding (IDLE, LOAD, START, DATA, PARITY, STOP)
//   PAR_MODE_*    - parity-mode values for the PARITY_ODD parameter
//   uart_div()    - clocks per bit, integer-truncated CLK_FREQ / BAUD
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } uart_state_e;

  localparam int PAR_MODE_EVEN = 0;
  localparam int PAR_MODE_ODD  = 1;

  function automatic int uart_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter. Counts 0..DIV-1 and wraps; clr_i forces
// the next count to 0 so each state starts a fresh bit period.
//   clk_i     in  clock
//   rst_n_i   in  asynchronous active-low reset
//   clr_i     in  restart the bit period on the next cycle
//   bit_end_o out high on the last cycle of a bit period (count == DIV-1)
module uart_baud_cnt #(
  parameter int DIV = 10
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  output logic bit_end_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    if (clr_i || (cnt_q == LAST)) cnt_d = '0;
    else                          cnt_d = cnt_q + 1'b1;
  end

  // Not gated by clr_i: the FSM uses bit_end to decide the transition that
  // raises clr_i, so gating would form a combinational loop.
  assign bit_end_o = (cnt_q == LAST);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// uart_tx_fifo_reader: UART transmitter fed from the read side of the TX
// async FIFO. Pops one word when the FIFO is non-empty (IDLE only), captures
// the registered read data one cycle later, and sends start / data (LSB
// first) / optional parity / stop bits on tx_o.
//   clk_i         in  read-domain clock
//   rst_n_i       in  asynchronous active-low reset
//   fifo_empty_i  in  FIFO empty flag, synchronous to clk_i
//   fifo_rd_en_o  out FIFO pop, one word per high cycle
//   fifo_data_i   in  FIFO read data, valid the cycle after fifo_rd_en_o
//   tx_o          out serial line, registered, idles high
//   busy_o        out high whenever the FSM is not in IDLE
//   done_o        out pulse on the last cycle of the final stop bit
// FIFO handshake: fifo_rd_en_o is a plain request with no ready; it is only
// raised in IDLE when fifo_empty_i is low, so every pop is a real word.
// DLY is accepted for compatibility with delay-annotated flows; the registers
// here are zero-delay.
module uart_tx_fifo_reader
  import uart_pkg::*;
#(
  parameter int DLY        = 1,
  parameter int DATA_WIDTH = 8,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int DIV = uart_div(CLK_FREQ, BAUD);
  localparam int BCW = $clog2(DATA_WIDTH + 1);
  localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_WIDTH - 1);
  localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);
  localparam logic           ODD_SEL   = (PARITY_ODD == PAR_MODE_ODD);

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                  tx_q, tx_d;
  logic                  bit_end;
  logic                  baud_clr;

  uart_baud_cnt #(.DIV(DIV)) u_baud (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clr_i     (baud_clr),
    .bit_end_o (bit_end)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (!fifo_empty_i) state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_START;
      ST_START:  if (bit_end) state_d = ST_DATA;
      ST_DATA:   if (bit_end && (bit_cnt_q == LAST_DATA))
                   state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_end) state_d = ST_STOP;
      ST_STOP:   if (bit_end && (bit_cnt_q == LAST_STOP)) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs and datapath next values
  always_comb begin
    fifo_rd_en_o = (state_q == ST_IDLE) && !fifo_empty_i;
    busy_o       = (state_q != ST_IDLE);
    done_o       = (state_q == ST_STOP) && bit_end && (bit_cnt_q == LAST_STOP);

    shift_d  = shift_q;
    parity_d = parity_q;
    if (state_q == ST_LOAD) begin
      shift_d  = fifo_data_i;
      parity_d = (^fifo_data_i) ^ ODD_SEL;
    end else if ((state_q == ST_DATA) && bit_end) begin
      shift_d = shift_q >> 1;
    end

    // Bit counter indexes data bits in DATA and stop bits in STOP.
    if (state_d != state_q)                                     bit_cnt_d = '0;
    else if (bit_end && ((state_q == ST_DATA) || (state_q == ST_STOP))) bit_cnt_d = bit_cnt_q + 1'b1;
    else                                                        bit_cnt_d = bit_cnt_q;

    // Restart the bit period on every state entry and while idle.
    baud_clr = (state_d != state_q) || (state_q == ST_IDLE);

    // tx is computed from the next state so the register changes exactly on
    // the first cycle of each bit.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = parity_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
    end else begin
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
    end
  end

  assign tx_o = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
module tb_uart_tx_fifo_reader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: 8N1, DIV = 10 ----------------
  logic       fifo_empty_a, rd_a, tx_a, busy_a, done_a;
  logic [7:0] data_a = 8'h00;
  logic [7:0] mem_a [0:15];
  int         wr_a = 0, rd_ptr_a = 0;
  logic       ovr_en = 1'b0, ovr_val = 1'b1;

  assign fifo_empty_a = ovr_en ? ovr_val : (wr_a == rd_ptr_a);

  always @(posedge clk)
    if (rd_a) begin
      data_a   <= mem_a[rd_ptr_a % 16];
      rd_ptr_a <= rd_ptr_a + 1;
    end

  uart_tx_fifo_reader #(
    .DATA_WIDTH(8), .CLK_FREQ(1_000_000), .BAUD(100_000),
    .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
  ) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .fifo_empty_i(fifo_empty_a),
    .fifo_rd_en_o(rd_a), .fifo_data_i(data_a),
    .tx_o(tx_a), .busy_o(busy_a), .done_o(done_a)
  );

  // ---------------- DUT B: 8O2, DIV = 10 ----------------
  logic       fifo_empty_b, rd_b, tx_b, busy_b, done_b;
  logic [7:0] data_b = 8'h00;
  logic [7:0] mem_b [0:15];
  int         wr_b = 0, rd_ptr_b = 0;

  assign fifo_empty_b = (wr_b == rd_ptr_b);

  always @(posedge clk)
    if (rd_b) begin
      data_b   <= mem_b[rd_ptr_b % 16];
      rd_ptr_b <= rd_ptr_b + 1;
    end

  uart_tx_fifo_reader #(
    .DATA_WIDTH(8), .CLK_FREQ(1_000_000), .BAUD(100_000),
    .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)
  ) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .fifo_empty_i(fifo_empty_b),
    .fifo_rd_en_o(rd_b), .fifo_data_i(data_b),
    .tx_o(tx_b), .busy_o(busy_b), .done_o(done_b)
  );

  // ---------------- pop monitor ----------------
  int rd_cnt_a = 0, rd_cnt_b = 0, viol = 0;
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (rd_a) begin
        rd_cnt_a++;
        if (fifo_empty_a || busy_a) viol++;
      end
      if (rd_b) begin
        rd_cnt_b++;
        if (fifo_empty_b || busy_b) viol++;
      end
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_a(input logic [7:0] b);
    mem_a[wr_a % 16] = b;
    wr_a++;
  endtask

  task automatic push_b(input logic [7:0] b);
    mem_b[wr_b % 16] = b;
    wr_b++;
  endtask

  // Returns 1 ns after the negedge of the cycle in which the read is issued.
  task automatic wait_rd(input string tag, input bit use_b);
    int k = 0;
    #1;
    while (!(use_b ? rd_b : rd_a) && k < 20) begin
      tick();
      #1;
      k++;
    end
    chk(tag, use_b ? rd_b : rd_a, 1);
  endtask

  // Called in the read cycle; checks LOAD through the last stop cycle.
  // bits[0] is the start bit; each bit lasts 10 cycles.
  task automatic frame_check(input string tag, input bit use_b,
                             input logic [15:0] bits, input int nbits);
    int flen = nbits * 10;
    logic exp_tx;
    for (int c = 1; c <= flen + 1; c++) begin
      tick();
      exp_tx = (c < 2) ? 1'b1 : bits[(c - 2) / 10];
      chk({tag, "_tx"},   use_b ? tx_b   : tx_a,   exp_tx);
      chk({tag, "_busy"}, use_b ? busy_b : busy_a, 1);
      chk({tag, "_done"}, use_b ? done_b : done_a, (c == flen + 1));
      chk({tag, "_rd"},   use_b ? rd_b   : rd_a,   0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset values
    repeat (3) tick();
    chk("rst_tx",   tx_a,   1);
    chk("rst_rd",   rd_a,   0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_tx_b", tx_b,   1);
    rst_n = 1'b1;

    // Idle with empty FIFO for 200 cycles
    for (int i = 0; i < 200; i++) begin
      tick();
      chk("idle_tx",   tx_a,   1);
      chk("idle_rd",   rd_a,   0);
      chk("idle_busy", busy_a, 0);
      chk("idle_done", done_a, 0);
      chk("idle_rd_b", rd_b,   0);
    end

    // Single frame 0xA5
    push_a(8'hA5);
    wait_rd("a5_read", 0);
    frame_check("a5", 0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10);
    tick();
    chk("a5_after_rd",   rd_a,   0);
    chk("a5_after_busy", busy_a, 0);
    chk("a5_after_done", done_a, 0);
    chk("a5_after_tx",   tx_a,   1);
    chk("a5_pops",       rd_cnt_a, 1);

    // Back-to-back 0x01, 0x80, 0xFF
    push_a(8'h01);
    push_a(8'h80);
    push_a(8'hFF);
    wait_rd("b2b_read0", 0);
    frame_check("b2b_01", 0, {6'b0, 1'b1, 8'h01, 1'b0}, 10);
    tick();
    chk("b2b_gap1_rd", rd_a, 1);
    chk("b2b_gap1_tx", tx_a, 1);
    frame_check("b2b_80", 0, {6'b0, 1'b1, 8'h80, 1'b0}, 10);
    tick();
    chk("b2b_gap2_rd", rd_a, 1);
    chk("b2b_gap2_tx", tx_a, 1);
    frame_check("b2b_ff", 0, {6'b0, 1'b1, 8'hFF, 1'b0}, 10);
    tick();
    chk("b2b_end_rd",   rd_a,   0);
    chk("b2b_end_busy", busy_a, 0);
    repeat (20) tick();
    chk("b2b_pops", rd_cnt_a, 4);

    // Parity odd, two stop bits, byte 0x03: parity bit 1, 120-cycle frame
    push_b(8'h03);
    wait_rd("par_read", 1);
    frame_check("par", 1, {4'b0, 2'b11, 1'b1, 8'h03, 1'b0}, 12);
    tick();
    chk("par_after_rd",   rd_b,   0);
    chk("par_after_busy", busy_b, 0);
    chk("par_after_tx",   tx_b,   1);

    // Reset during data bit 3 of 0x55
    push_a(8'h55);
    wait_rd("rst_read", 0);
    for (int c = 1; c <= 45; c++) tick();
    chk("rstmid_pre_tx",   tx_a,   0);
    chk("rstmid_pre_busy", busy_a, 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_tx",   tx_a,   1);
    chk("rstmid_busy", busy_a, 0);
    chk("rstmid_rd",   rd_a,   0);
    chk("rstmid_done", done_a, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 150; i++) begin
      tick();
      chk("postrst_rd",   rd_a,   0);
      chk("postrst_done", done_a, 0);
      chk("postrst_tx",   tx_a,   1);
      chk("postrst_busy", busy_a, 0);
    end
    chk("postrst_pops", rd_cnt_a, 5);

    // Empty toggling during a frame; read only in IDLE with empty low
    push_a(8'h3C);
    push_a(8'hC3);
    wait_rd("tog_read", 0);
    for (int c = 1; c <= 101; c++) begin
      tick();
      ovr_en  = 1'b1;
      ovr_val = (c % 2 == 1);
      #1;
      chk("tog_busy_rd", rd_a, 0);
      chk("tog_busy",    busy_a, 1);
    end
    tick();
    ovr_val = 1'b1;
    #1;
    chk("tog_idle_empty_rd", rd_a,   0);
    chk("tog_idle_busy",     busy_a, 0);
    tick();
    ovr_val = 1'b0;
    #1;
    chk("tog_idle_read", rd_a, 1);
    ovr_en = 1'b0;
    frame_check("tog_c3", 0, {6'b0, 1'b1, 8'hC3, 1'b0}, 10);
    tick();
    chk("tog_end_rd", rd_a, 0);
    chk("tog_end_tx", tx_a, 1);

    repeat (5) tick();
    chk("total_pops_a", rd_cnt_a, 7);
    chk("total_pops_b", rd_cnt_b, 1);
    chk("pop_protocol", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
